morse_tone_sequencer: RTL and testbench

MORSE_TONE_SEQUENCER -- requirements
Module: morse_tone_sequencer

---
 rtl/morse_pkg.sv | 37 +++
 rtl/tone_gen.sv | 37 +++
 rtl/morse_tone_sequencer.sv | 159 +++++++++++++++
 tb/tb_morse_tone_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_pkg
//  Purpose  : Shared state encoding, element codes and timing multiples for
//             the Morse tone sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package morse_pkg;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MARK = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_LGAP = 2'd3;

    // Element codes as carried in sym_bits
    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Durations in Morse time units
    localparam logic [2:0] UNITS_DOT  = 3'd1;
    localparam logic [2:0] UNITS_DASH = 3'd3;
    localparam logic [2:0] GAP_ELEM   = 3'd1;
    localparam logic [2:0] GAP_CHAR   = 3'd3;
    localparam logic [2:0] GAP_WORD   = 3'd7;

    // Longest symbol the sequencer will play
    localparam logic [2:0] MAX_LEN = 3'd5;

    // Lengths 6 and 7 are treated as the longest legal symbol
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Free-running square wave, high for TONE_HIGH cycles out of
//             every TONE_PERIOD cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
    parameter int TONE_PERIOD = 1_000_000,
    parameter int TONE_HIGH   = 500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tone
);

    localparam int                c_cw       = (TONE_PERIOD > 2) ? $clog2(TONE_PERIOD) : 1;
    localparam logic [c_cw-1:0]   c_cnt_last = c_cw'(TONE_PERIOD - 1);
    localparam logic [c_cw-1:0]   c_cnt_high = c_cw'(TONE_HIGH);

    logic [c_cw-1:0] r_cnt;

    // Phase counter wrapping every TONE_PERIOD cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tone = (r_cnt < c_cnt_high);

endmodule
`default_nettype wire

// File: rtl/morse_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tone_sequencer
//  Purpose  : Plays one Morse symbol (up to five dots/dashes, or a word
//             space) as a gated square-wave tone, with manual-key sidetone
//             while idle.
//  Revision : 1.0  initial release
// ============================================================================
module morse_tone_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int TONE_PERIOD = 1_000_000,
    parameter int TONE_HIGH   = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [4:0] sym_bits,
    input  logic [2:0] sym_len,
    input  logic       abort,
    input  logic       key_in,
    output logic       busy,
    output logic       done,
    output logic       beep
);

    // Timer must reach 7*UNIT_CYCLES-1 (the word space) without wrapping
    localparam int c_tw = $clog2(7 * UNIT_CYCLES);

    state_t          r_state;
    logic [c_tw-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [4:0]      r_bits;
    logic [2:0]      r_len;
    logic            r_done;
    logic            r_beep;

    logic            w_accept;
    logic            w_elem;
    logic [2:0]      w_units;
    logic [c_tw-1:0] w_last;
    logic            w_expire;
    logic            w_gate;
    logic            w_tone;

    // Ready only while idle and out of reset
    assign sym_ready = rst & (r_state == ST_IDLE);
    assign w_accept  = sym_valid & sym_ready & ~abort;
    assign w_elem    = r_bits[r_idx];

    // Length of the current state in units; the long gap doubles as word space
    always_comb begin
        w_units = GAP_ELEM;
        case (r_state)
            ST_MARK: w_units = (w_elem == DOT) ? UNITS_DOT : UNITS_DASH;
            ST_GAP:  w_units = GAP_ELEM;
            ST_LGAP: w_units = (r_len == 3'd0) ? GAP_WORD : GAP_CHAR;
            default: w_units = GAP_ELEM;
        endcase
    end

    assign w_last   = c_tw'(int'(w_units) * UNIT_CYCLES - 1);
    assign w_expire = (r_timer == w_last);

    // Playback state machine with abort as the highest-priority exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_bits  <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bits  <= sym_bits;
                        r_len   <= clamp_len(sym_len);
                        r_idx   <= '0;
                        r_timer <= '0;
                        r_state <= (sym_len == 3'd0) ? ST_LGAP : ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (w_expire) begin
                        r_timer <= '0;
                        if ((r_idx + 3'd1) < r_len) begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_LGAP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_expire) begin
                        r_timer <= '0;
                        r_state <= ST_MARK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_LGAP: begin
                    if (w_expire) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    tone_gen #(
        .TONE_PERIOD (TONE_PERIOD),
        .TONE_HIGH   (TONE_HIGH)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .tone (w_tone)
    );

    // Key input only reaches the buzzer while idle
    assign w_gate = (r_state == ST_MARK) | ((r_state == ST_IDLE) & key_in);

    // Buzzer pin registered to keep it glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beep <= 1'b0;
        end else begin
            r_beep <= w_tone & w_gate;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign beep = r_beep;

endmodule
`default_nettype wire

// File: tb/tb_morse_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_tone_sequencer
//  Purpose  : Self-checking bench; expected behaviour is rebuilt per symbol
//             as a cycle-by-cycle tone-gate timeline from the Morse timing
//             rules, with the tone phase counted from reset release.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_tone_sequencer;

    localparam int U  = 4;
    localparam int TP = 2;
    localparam int TH = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [4:0] sym_bits = '0;
    logic [2:0] sym_len = '0;
    logic       abort = 1'b0;
    logic       key_in = 1'b0;
    logic       busy;
    logic       done;
    logic       beep;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit exp_beep = 1'b0;

    morse_tone_sequencer #(
        .UNIT_CYCLES (U),
        .TONE_PERIOD (TP),
        .TONE_HIGH   (TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_bits  (sym_bits),
        .sym_len   (sym_len),
        .abort     (abort),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .beep      (beep)
    );

    always #5 clk = ~clk;

    function automatic bit tone_of(input int c);
        return ((c % TP) < TH);
    endfunction

    // Advance one clock; gate is the buzzer gate during the cycle being left
    task automatic tick(input bit gate);
        exp_beep = gate & tone_of(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_idle(input int n, input bit rand_key);
        for (int i = 0; i < n; i++) begin
            if (rand_key) key_in = 1'($urandom_range(0, 1));
            tick(key_in);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done got=%b want=0", done); end
            checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b want=1", sym_ready); end
            checks++; if (beep !== exp_beep) begin errors++; $display("FAIL idle_beep cyc=%0d got=%b want=%b", cyc, beep, exp_beep); end
        end
    endtask

    // Plays one symbol starting with the current cycle as the acceptance
    // cycle, and returns sampled on the expected done cycle.
    task automatic run_symbol(input logic [4:0] bits, input logic [2:0] len,
                              input bit rand_key, input bit hold,
                              input logic [4:0] nbits, input logic [2:0] nlen,
                              input string tag);
        bit mark_q[$];
        int L;
        int n;
        L = (len > 3'd5) ? 5 : int'(len);
        if (L == 0) begin
            repeat (7*U) mark_q.push_back(1'b0);
        end else begin
            for (int e = 0; e < L; e++) begin
                repeat (bits[e] ? 3*U : U) mark_q.push_back(1'b1);
                if (e < L-1) repeat (U) mark_q.push_back(1'b0);
            end
            repeat (3*U) mark_q.push_back(1'b0);
        end
        n = mark_q.size();

        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got=%b want=1", tag, sym_ready); end
        sym_valid = 1'b1;
        sym_bits  = bits;
        sym_len   = len;
        if (rand_key) key_in = 1'($urandom_range(0, 1));
        tick(key_in);
        sym_valid = hold;
        sym_bits  = hold ? nbits : 5'($urandom);
        sym_len   = hold ? nlen  : 3'($urandom);

        for (int k = 0; k < n; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy k=%0d got=%b want=1", tag, k, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s early_done k=%0d got=%b want=0", tag, k, done); end
            checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL %s ready k=%0d got=%b want=0", tag, k, sym_ready); end
            checks++; if (beep !== exp_beep) begin errors++; $display("FAIL %s beep k=%0d got=%b want=%b", tag, k, beep, exp_beep); end
            if (rand_key) key_in = 1'($urandom_range(0, 1));
            tick(mark_q[k]);
        end

        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s end_busy got=%b want=0", tag, busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got=%b want=1", tag, done); end
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL %s end_ready got=%b want=1", tag, sym_ready); end
        checks++; if (beep !== exp_beep) begin errors++; $display("FAIL %s end_beep got=%b want=%b", tag, beep, exp_beep); end
        if (!hold) sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL rst_beep got=%b want=0", beep); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", sym_ready); end
        rst = 1'b1;
        cyc = 0;
        #1;
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b want=1", sym_ready); end
        test_idle(3, 1'b0);
    endtask

    task automatic test_letter_a();
        run_symbol(5'b00010, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0, "letter_a");
        test_idle(3, 1'b0);
    endtask

    task automatic test_word_space();
        run_symbol(5'b10110, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, "word_space");
        test_idle(2, 1'b0);
    endtask

    task automatic test_clamp();
        run_symbol(5'b11111, 3'd7, 1'b0, 1'b0, 5'd0, 3'd0, "clamp");
        test_idle(2, 1'b0);
    endtask

    task automatic test_sidetone();
        int ones;
        ones = 0;
        key_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            if (beep === 1'b1) ones++;
            checks++; if (beep !== exp_beep) begin errors++; $display("FAIL sidetone_beep i=%0d got=%b want=%b", i, beep, exp_beep); end
        end
        checks++; if (ones != 4) begin errors++; $display("FAIL sidetone_toggle ones=%0d want=4", ones); end
        key_in = 1'b0;
        test_idle(2, 1'b0);
    endtask

    task automatic test_abort();
        // Abort midway through the dash of "A"
        sym_valid = 1'b1; sym_bits = 5'b00010; sym_len = 3'd2;
        tick(1'b0);
        sym_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy k=%0d got=%b want=1", k, busy); end
            tick((k < 4) || (k >= 8));
        end
        abort = 1'b1;
        tick(1'b1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", sym_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
        checks++; if (beep !== exp_beep) begin errors++; $display("FAIL abort_beep0 got=%b want=%b", beep, exp_beep); end
        tick(1'b0);
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL abort_beep1 got=%b want=0", beep); end
        test_idle(40, 1'b0);
        // Abort alongside a valid symbol in idle drops the symbol
        abort = 1'b1; sym_valid = 1'b1; sym_bits = 5'b00001; sym_len = 3'd1;
        tick(1'b0);
        abort = 1'b0; sym_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_drop_busy got=%b want=0", busy); end
        test_idle(3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_symbol(5'b00010, 3'd2, 1'b0, 1'b1, 5'b00101, 3'd3, "b2b_first");
        run_symbol(5'b00101, 3'd3, 1'b0, 1'b0, 5'd0, 3'd0, "b2b_second");
        test_idle(2, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] b;
        logic [2:0] l;
        for (int i = 0; i < 8; i++) begin
            b = 5'($urandom);
            l = 3'($urandom_range(0, 7));
            run_symbol(b, l, 1'b1, 1'b0, 5'd0, 3'd0, "random");
            test_idle(int'($urandom_range(1, 5)), 1'b1);
        end
        key_in = 1'b0;
        test_idle(1, 1'b0);
    endtask

    task automatic test_async_reset();
        sym_valid = 1'b1; sym_bits = 5'b00010; sym_len = 3'd2;
        tick(1'b0);
        sym_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick(k < 4);
        // Now inside the inter-element gap; reset without a clock edge
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b want=0", busy); end
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL arst_beep got=%b want=0", beep); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b want=0", done); end
        checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b want=0", sym_ready); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_hold_done got=%b want=0", done); end
        rst = 1'b1;
        cyc = 0;
        #1;
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL arst_rel_ready got=%b want=1", sym_ready); end
        test_idle(40, 1'b0);
        run_symbol(5'b00001, 3'd1, 1'b0, 1'b0, 5'd0, 3'd0, "post_reset");
        test_idle(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_word_space();
        test_clamp();
        test_sidetone();
        test_abort();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
